// File: rtl/odd_count_monitor.sv
// Consumer-side sequence checker for an odd counter: locks onto 1,3,5,...,255,1,...
// and reports every deviation while locked, with a saturating error count.
`timescale 1ns/1ps
module odd_count_monitor #(
    parameter int WIDTH     = 8,
    parameter int LOCK_CNT  = 4,
    parameter int ERR_LIMIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             sample_en_i,
    input  logic             clr_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [15:0]      err_count_o,
    output logic [WIDTH-1:0] expected_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_N = LOCK_CNT[3:0];
    localparam logic [3:0] ERR_N  = ERR_LIMIT[3:0];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] ref_r, ref_s, step_s, expected_s;
    logic [3:0]       good_run_r, good_run_s, bad_run_r, bad_run_s;
    logic [15:0]      err_count_s;
    logic             err_s, match_s, odd_s;

    // Next-state, reference and run-counter evaluation for the current sample
    always_comb begin
        step_s     = ref_r + WIDTH'(2);
        match_s    = (cnt_i == step_s);
        odd_s      = cnt_i[0];
        state_s    = state_r;
        ref_s      = ref_r;
        good_run_s = good_run_r;
        bad_run_s  = bad_run_r;
        err_s      = 1'b0;
        if (sample_en_i) begin
            case (state_r)
                HUNT: begin
                    if (odd_s) begin
                        ref_s      = cnt_i;
                        good_run_s = 4'd0;
                        state_s    = SYNC;
                    end else begin
                        state_s = HUNT;
                    end
                end
                SYNC: begin
                    if (!odd_s) begin
                        state_s = HUNT;
                    end else if (match_s) begin
                        ref_s      = cnt_i;
                        good_run_s = good_run_r + 4'd1;
                        if (good_run_r + 4'd1 == LOCK_N) begin
                            state_s = LOCKED;
                        end else begin
                            state_s = SYNC;
                        end
                    end else begin
                        ref_s      = cnt_i;
                        good_run_s = 4'd0;
                    end
                end
                LOCKED: begin
                    if (match_s) begin
                        ref_s = cnt_i;
                    end else begin
                        // odd samples resync the reference, even ones freewheel it
                        err_s     = 1'b1;
                        bad_run_s = 4'd1;
                        ref_s     = odd_s ? cnt_i : step_s;
                        state_s   = (ERR_LIMIT == 1) ? HUNT : ERR;
                    end
                end
                ERR: begin
                    if (match_s) begin
                        ref_s     = cnt_i;
                        bad_run_s = 4'd0;
                        state_s   = LOCKED;
                    end else begin
                        err_s     = 1'b1;
                        bad_run_s = bad_run_r + 4'd1;
                        ref_s     = odd_s ? cnt_i : step_s;
                        if (bad_run_r + 4'd1 == ERR_N) begin
                            state_s = HUNT;
                        end else begin
                            state_s = ERR;
                        end
                    end
                end
                default: begin
                    state_s = HUNT;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        // an error on the same edge as a clear leaves exactly that one error counted
        if (err_s) begin
            err_count_s = clr_i ? 16'd1 : sat_inc(err_count_o);
        end else if (clr_i) begin
            err_count_s = 16'd0;
        end else begin
            err_count_s = err_count_o;
        end

        if (state_s == HUNT) begin
            expected_s = '0;
        end else begin
            expected_s = ref_s + WIDTH'(2);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= HUNT;
            ref_r       <= '0;
            good_run_r  <= 4'd0;
            bad_run_r   <= 4'd0;
            locked_o    <= 1'b0;
            err_o       <= 1'b0;
            err_count_o <= 16'd0;
            expected_o  <= '0;
            state_o     <= 2'd0;
        end else begin
            state_r     <= state_s;
            ref_r       <= ref_s;
            good_run_r  <= good_run_s;
            bad_run_r   <= bad_run_s;
            locked_o    <= (state_s == LOCKED) || (state_s == ERR);
            err_o       <= err_s;
            err_count_o <= err_count_s;
            expected_o  <= expected_s;
            state_o     <= state_s;
        end
    end

endmodule

// File: tb/tb_odd_count_monitor.sv
// Scoreboard bench for odd_count_monitor: directed samples push hand-computed
// expectations; a monitor process checks them after each clock edge.
`timescale 1ns/1ps
module tb_odd_count_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  cnt_i = 8'd0;
    logic        sample_en_i = 1'b0;
    logic        clr_i = 1'b0;
    logic        locked_o;
    logic        err_o;
    logic [15:0] err_count_o;
    logic [7:0]  expected_o;
    logic [1:0]  state_o;

    typedef struct {
        logic        l;
        logic        e;
        logic [15:0] c;
        logic [7:0]  x;
        logic [1:0]  s;
        int          id;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   step_id = 0;

    odd_count_monitor #(.WIDTH(8), .LOCK_CNT(4), .ERR_LIMIT(3)) dut (
        .clk(clk), .reset(reset), .cnt_i(cnt_i), .sample_en_i(sample_en_i),
        .clr_i(clr_i), .locked_o(locked_o), .err_o(err_o),
        .err_count_o(err_count_o), .expected_o(expected_o), .state_o(state_o)
    );

    always #50 clk = ~clk;

    task automatic chk(input string name, input int id, input logic l, input logic e,
                       input logic [15:0] c, input logic [7:0] x, input logic [1:0] s);
        tests++;
        if (locked_o !== l || err_o !== e || err_count_o !== c || expected_o !== x || state_o !== s) begin
            fails++;
            $display("FAIL %s #%0d: got locked=%b err=%b cnt=%0d exp=%0d st=%0d, want locked=%b err=%b cnt=%0d exp=%0d st=%0d",
                     name, id, locked_o, err_o, err_count_o, expected_o, state_o, l, e, c, x, s);
        end
    endtask

    task automatic step(input logic [7:0] v, input logic en, input logic clr,
                        input logic l, input logic e, input logic [15:0] c,
                        input logic [7:0] x, input logic [1:0] s);
        exp_t t;
        @(negedge clk);
        cnt_i = v;
        sample_en_i = en;
        clr_i = clr;
        t.l = l; t.e = e; t.c = c; t.x = x; t.s = s; t.id = step_id;
        step_id++;
        q.push_back(t);
    endtask

    // Monitor: one expectation consumed per clock edge after it was issued
    initial begin
        exp_t t;
        forever begin
            @(posedge clk);
            if (q.size() > 0) begin
                #2;
                t = q.pop_front();
                chk("sample", t.id, t.l, t.e, t.c, t.x, t.s);
            end
        end
    end

    initial begin
        #10 reset = 1'b1;
        #95 chk("reset_state", -1, 1'b0, 1'b0, 16'd0, 8'd0, 2'd0);
        #5 reset = 1'b0;

        // acquire lock on 1,3,5,7,9
        step(8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd3, 2'd1);
        step(8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd5, 2'd1);
        step(8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd7, 2'd1);
        step(8'd7, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd9, 2'd1);
        step(8'd9, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd11, 2'd2);

        // run up through the wrap 255 -> 1
        for (int v = 11; v <= 255; v += 2)
            step(8'(v), 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'(v + 2), 2'd2);
        step(8'd1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd3, 2'd2);
        step(8'd3, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd5, 2'd2);

        // single odd glitch then recovery
        for (int v = 5; v <= 19; v += 2)
            step(8'(v), 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'(v + 2), 2'd2);
        step(8'd25, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 8'd27, 2'd3);
        step(8'd27, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 8'd29, 2'd2);

        // three even mismatches drop lock
        step(8'd29, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 8'd31, 2'd2);
        step(8'd40, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2, 8'd33, 2'd3);
        step(8'd50, 1'b1, 1'b0, 1'b1, 1'b1, 16'd3, 8'd35, 2'd3);
        step(8'd60, 1'b1, 1'b0, 1'b0, 1'b1, 16'd4, 8'd0, 2'd0);

        // relock, then asynchronous reset between edges
        for (int v = 61; v <= 67; v += 2)
            step(8'(v), 1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 8'(v + 2), 2'd1);
        step(8'd69, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4, 8'd71, 2'd2);
        @(negedge clk);
        sample_en_i = 1'b0;
        #5 reset = 1'b1;
        #30 chk("async_reset", -2, 1'b0, 1'b0, 16'd0, 8'd0, 2'd0);
        reset = 1'b0;
        for (int v = 7; v <= 13; v += 2)
            step(8'(v), 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'(v + 2), 2'd1);
        step(8'd15, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd17, 2'd2);

        // hold while sample_en_i is low, then clear coinciding with an error
        for (int i = 0; i < 3; i++)
            step(8'd100, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 8'd17, 2'd2);
        step(8'd100, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1, 8'd19, 2'd3);
        step(8'd100, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 8'd19, 2'd3);
        step(8'd19, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 8'd21, 2'd2);
        step(8'd30, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 8'd23, 2'd3);
        step(8'd23, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 8'd25, 2'd2);
        step(8'd40, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2, 8'd27, 2'd3);
        step(8'd50, 1'b1, 1'b0, 1'b1, 1'b1, 16'd3, 8'd29, 2'd3);
        step(8'd60, 1'b1, 1'b0, 1'b0, 1'b1, 16'd4, 8'd0, 2'd0);

        // HUNT/SYNC edge cases: even in HUNT, even in SYNC, odd mismatch in SYNC
        step(8'd4,  1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 8'd0, 2'd0);
        step(8'd5,  1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 8'd7, 2'd1);
        step(8'd8,  1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 8'd0, 2'd0);
        step(8'd9,  1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 8'd11, 2'd1);
        step(8'd15, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 8'd17, 2'd1);
        step(8'd17, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 8'd19, 2'd1);

        @(negedge clk);
        sample_en_i = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
